key_serializer: RTL and testbench

- Transmit-side counterpart of the 512-bit key assembly path.
- Takes a fully assembled 512-bit key (or cipher block) in parallel and streams it out one bit per accepted transfer, 32-bit word by word.
- Word 0 is bits [31:0], matching the order in which the assembler fills the register.
- Sits between the key/ciphertext register and the serial output link. Uses a valid/ready handshake so the downstream consumer may stall.

---
 rtl/key_serializer.sv | 124 ++++++++++++
 tb/tb_key_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/key_serializer.sv
// Purpose: streams a parallel 512-bit key/cipher block out one bit per transfer, word 0 first, MSB-first per word.
// Latency: first bit valid the cycle after an accepted load; oDone one cycle after the final transfer.
// Backpressure: iReady low freezes the bit, counters and state; stalls may be of any length.
module key_serializer #(
  parameter int BLOCK_W = 512,
  parameter int WORD_W  = 32
) (
  input  logic                                  iClk,
  input  logic                                  iRst,
  input  logic [BLOCK_W-1:0]                    iBlock,
  input  logic                                  iLoad,
  input  logic                                  iReady,
  output logic                                  oBit,
  output logic                                  oValid,
  output logic [$clog2(WORD_W):0]               oBit_counter,
  output logic [$clog2(BLOCK_W/WORD_W)-1:0]     oWord_counter,
  output logic                                  oWord_done,
  output logic                                  oBusy,
  output logic                                  oDone
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int BCW    = $clog2(WORD_W) + 1;
  localparam int WCW    = $clog2(NWORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BLOCK_W-1:0] r_shift;
  logic [BCW-1:0]     r_bit_cnt;
  logic [WCW-1:0]     r_word_cnt;
  logic               r_word_done;

  logic               w_load;
  logic               w_xfer;
  logic               w_last_bit;
  logic               w_last_word;

  assign w_last_bit  = (r_bit_cnt == BCW'(WORD_W - 1));
  assign w_last_word = (r_word_cnt == WCW'(NWORDS - 1));

  // The current word always sits in r_shift[WORD_W-1:0]; its MSB is the live bit,
  // so oBit comes straight off a flop and never depends on iReady combinationally.
  assign oBit          = r_shift[WORD_W-1];
  assign oBit_counter  = r_bit_cnt;
  assign oWord_counter = r_word_cnt;
  assign oWord_done    = r_word_done;

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived outputs; load only in IDLE, transfer only in SHIFT.
  always_comb begin
    w_state_nxt = r_state;
    oValid      = 1'b0;
    oBusy       = 1'b0;
    oDone       = 1'b0;
    w_load      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iLoad) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        oValid = 1'b1;
        oBusy  = 1'b1;
        w_xfer = iReady;
        if (iReady && w_last_bit && w_last_word) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        oDone       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture on load; on each transfer shift within the word, or drop the
  // finished word and pull the next one down at a word boundary. Counters wrap explicitly.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (w_load) begin
        r_shift    <= iBlock;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (w_xfer) begin
        if (w_last_bit) begin
          r_shift     <= {{WORD_W{1'b0}}, r_shift[BLOCK_W-1:WORD_W]};
          r_bit_cnt   <= '0;
          r_word_done <= 1'b1;
          r_word_cnt  <= w_last_word ? '0 : r_word_cnt + WCW'(1);
        end else begin
          r_shift   <= {r_shift[BLOCK_W-1:WORD_W], r_shift[WORD_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + BCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_serializer.sv
// Directed bench for key_serializer: reset, full block, backpressure, load while busy,
// mid-block reset and back-to-back loads, with expected values computed here.
module tb_key_serializer;

  localparam int BW = 512;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          iRst;
  logic [BW-1:0] iBlock;
  logic          iLoad;
  logic          iReady;
  logic          oBit;
  logic          oValid;
  logic [5:0]    oBit_counter;
  logic [3:0]    oWord_counter;
  logic          oWord_done;
  logic          oBusy;
  logic          oDone;

  key_serializer #(.BLOCK_W(BW), .WORD_W(WW)) dut (
    .iClk          (clk),
    .iRst          (iRst),
    .iBlock        (iBlock),
    .iLoad         (iLoad),
    .iReady        (iReady),
    .oBit          (oBit),
    .oValid        (oValid),
    .oBit_counter  (oBit_counter),
    .oWord_counter (oWord_counter),
    .oWord_done    (oWord_done),
    .oBusy         (oBusy),
    .oDone         (oDone)
  );

  always #5 clk = ~clk;

  // {valid, busy, done, word_done, bit, bit_counter, word_counter}
  logic [14:0] outs;
  assign outs = {oValid, oBusy, oDone, oWord_done, oBit, oBit_counter, oWord_counter};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [BW-1:0] b, input int k);
    return b[WW * (k / WW) + (WW - 1) - (k % WW)];
  endfunction

  logic [BW-1:0] last_stream;
  logic [BW-1:0] ref_stream;
  logic [31:0]   last_w0;
  int            last_cycles;
  int            wd_count;
  int            done_count;

  localparam logic [BW-1:0] PAT = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [BW-1:0] ALT = {16{32'hA5C3_0F96}};

  // Load blk, then stream it out while checking every cycle against the model.
  // alt is driven on iBlock after capture; load_at re-asserts iLoad at that bit;
  // abort_at asserts reset at that bit; hold_load keeps iLoad high throughout.
  task automatic run_block(input logic [BW-1:0] blk, input logic [BW-1:0] alt,
                           input int stall_pct, input int load_at, input int abort_at,
                           input bit hold_load, input string nm);
    int          k;
    int          iters;
    bit          xfer;
    logic        wd_exp;
    logic [31:0] w0;
    k = 0; iters = 0; wd_exp = 1'b0; w0 = '0;
    wd_count = 0; done_count = 0; last_stream = '0;
    iBlock = blk; iLoad = 1'b1; iReady = 1'b1;
    @(posedge clk); #1;
    if (!hold_load) iLoad = 1'b0;
    iBlock = alt;
    while (k < BW) begin
      if (iters >= 4000) begin
        check({nm, "_timeout"}, 64'(k), 64'(BW));
        return;
      end
      iReady = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      if (k == load_at) iLoad = 1'b1;
      check({nm, "_shift"}, 64'(outs),
            64'({1'b1, 1'b1, 1'b0, wd_exp, exp_bit(blk, k), 6'(k % WW), 4'(k / WW)}));
      if (oWord_done) wd_count++;
      if (k == abort_at) begin
        iRst = 1'b1; #1;
        check({nm, "_async_rst"}, 64'(outs), 64'd0);
        repeat (2) @(posedge clk);
        #1; iRst = 1'b0; iReady = 1'b1; iLoad = 1'b0;
        repeat (6) begin
          @(posedge clk); #1;
          check({nm, "_post_rst_idle"}, 64'(outs), 64'd0);
        end
        return;
      end
      xfer = iReady;
      if (xfer) last_stream[k] = oBit;
      if (xfer && k < WW) w0 = {w0[30:0], oBit};
      @(posedge clk); #1;
      iters++;
      if (xfer) begin
        wd_exp = ((k % WW) == WW - 1);
        k++;
      end else begin
        wd_exp = 1'b0;
      end
    end
    if (!hold_load) iLoad = 1'b0;
    // DONE cycle: done and final word_done together, not valid, counters wrapped.
    check({nm, "_done_cycle"}, 64'(outs), 64'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 4'd0}));
    if (oWord_done) wd_count++;
    if (oDone) done_count++;
    last_cycles = iters + 1;
    last_w0 = w0;
    @(posedge clk); #1;
    check({nm, "_idle_after"}, 64'(outs), 64'd0);
  endtask

  initial begin
    iRst = 1'b1; iLoad = 1'b0; iReady = 1'b0; iBlock = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold", 64'(outs), 64'd0);
    end
    iRst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("idle", 64'(outs), 64'd0);
    end

    // Full block, no stalls.
    run_block(PAT, ~PAT, 0, -1, -1, 1'b0, "nostall");
    check("first_bit", 64'(last_stream[0]), 64'd1);
    check("bit32", 64'(last_stream[32]), 64'd0);
    check("word0_stream", 64'(last_w0), 64'h89AB_CDEF);
    check("nostall_latency", 64'(last_cycles), 64'd513);
    check("nostall_word_done_cnt", 64'(wd_count), 64'd16);
    check("nostall_done_cnt", 64'(done_count), 64'd1);
    ref_stream = last_stream;

    // 50% backpressure.
    run_block(PAT, ~PAT, 50, -1, -1, 1'b0, "stall");
    check("stall_stream_eq", 64'(last_stream == ref_stream), 64'd1);
    check("stall_word_done_cnt", 64'(wd_count), 64'd16);
    check("stall_done_cnt", 64'(done_count), 64'd1);

    // Load request with a different block at bit 100 is ignored.
    run_block(PAT, ALT, 0, 100, -1, 1'b0, "ldbusy");
    check("ldbusy_stream_eq", 64'(last_stream == ref_stream), 64'd1);
    check("ldbusy_done_cnt", 64'(done_count), 64'd1);

    // Reset at word 7 bit 12, then a fresh block from word 0 bit 0.
    run_block(PAT, ~PAT, 0, -1, 7 * 32 + 12, 1'b0, "abort");
    run_block(ALT, PAT, 0, -1, -1, 1'b0, "after_rst");
    check("after_rst_done_cnt", 64'(done_count), 64'd1);

    // Back-to-back with iLoad held high: second load lands in the IDLE cycle.
    run_block(PAT, ALT, 0, -1, -1, 1'b1, "b2b_a");
    check("b2b_a_done_cnt", 64'(done_count), 64'd1);
    run_block(ALT, ALT, 0, -1, -1, 1'b0, "b2b_b");
    check("b2b_b_latency", 64'(last_cycles), 64'd513);
    check("b2b_b_word_done_cnt", 64'(wd_count), 64'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
